// File: rtl/quantser_pkg.sv
// Shared definitions for the quantser controller: state encoding and the
// width constants derived from the default input bit depth.
package quantser_pkg;

    localparam int QS_BWIN     = 32;
    localparam int QS_BWMSBIDX = $clog2(QS_BWIN);
    localparam int QS_BWPREC   = $clog2(QS_BWIN) + 1;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_LOAD = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } qs_state_e;

endpackage : quantser_pkg

// File: rtl/quantser_ctrl.sv
// Sequencer for one quantser: accepts a conversion request, loads the
// shift register, then steps it once per accepted output bit.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   INIT  | clear the quantser for one cycle after reset release
//   IDLE  | ready for a request; latches msbidx/prec on accept
//   LOAD  | one-cycle q_load while upstream holds din
//   EMIT  | present bit count_q; step on each downstream handshake
//   DONE  | one-cycle done pulse, start ignored
module quantser_ctrl
    import quantser_pkg::*;
#(
    parameter int BWIN     = QS_BWIN,
    parameter int BWMSBIDX = $clog2(BWIN),
    parameter int BWPREC   = $clog2(BWIN) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                start_ready,
    input  logic [BWMSBIDX-1:0] msbidx_in,
    input  logic [BWPREC-1:0]   prec_in,
    output logic                q_clr,
    output logic                q_load,
    output logic                q_step,
    output logic [BWMSBIDX-1:0] q_msbidx,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic [BWPREC-1:0]   bit_idx,
    output logic                bit_last,
    output logic                done
);

    localparam logic [BWPREC-1:0] PREC_MAX = BWPREC'(BWIN);

    qs_state_e             state_q, state_d;
    logic [BWPREC-1:0]     count_q, count_d;
    logic [BWPREC-1:0]     prec_q, prec_d;
    logic [BWMSBIDX-1:0]   msbidx_q, msbidx_d;
    logic                  start_ready_q, start_ready_d;
    logic                  q_clr_q, q_clr_d;
    logic                  q_load_q, q_load_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  bit_last_q, bit_last_d;
    logic                  done_q, done_d;
    logic                  handshake;

    assign handshake = bit_valid_q && bit_ready;

    // Next-state logic; outputs are precomputed from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        prec_d   = prec_q;
        msbidx_d = msbidx_q;
        unique case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (start) begin
                    msbidx_d = msbidx_in;
                    prec_d   = (prec_in > PREC_MAX) ? PREC_MAX : prec_in;
                    state_d  = (prec_in == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (handshake) begin
                    if (bit_last_q) state_d = ST_DONE;
                    else            count_d = count_q + BWPREC'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase

        start_ready_d = (state_d == ST_IDLE);
        q_clr_d       = (state_d == ST_INIT);
        q_load_d      = (state_d == ST_LOAD);
        bit_valid_d   = (state_d == ST_EMIT);
        bit_last_d    = (state_d == ST_EMIT) && (count_d == prec_d - BWPREC'(1));
        done_d        = (state_d == ST_DONE);
    end

    // Controller state, latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            count_q       <= '0;
            prec_q        <= '0;
            msbidx_q      <= '0;
            start_ready_q <= 1'b0;
            q_clr_q       <= 1'b1;
            q_load_q      <= 1'b0;
            bit_valid_q   <= 1'b0;
            bit_last_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            prec_q        <= prec_d;
            msbidx_q      <= msbidx_d;
            start_ready_q <= start_ready_d;
            q_clr_q       <= q_clr_d;
            q_load_q      <= q_load_d;
            bit_valid_q   <= bit_valid_d;
            bit_last_q    <= bit_last_d;
            done_q        <= done_d;
        end
    end

    assign start_ready = start_ready_q;
    assign q_clr       = q_clr_q;
    assign q_load      = q_load_q;
    assign q_step      = handshake;
    assign q_msbidx    = msbidx_q;
    assign bit_valid   = bit_valid_q;
    assign bit_idx     = count_q;
    assign bit_last    = bit_last_q;
    assign done        = done_q;

endmodule : quantser_ctrl

// File: doc/quantser_ctrl.md
Name: quantser_ctrl

Overview:
- Sequencer that drives one quantser instance: latches a conversion request, issues the load, then steps the serializer one bit per downstream handshake.
- Tags each emitted bit with its bit-plane index and a last flag.
- Sits between the accumulator/result-select logic (upstream, which presents din to the quantser) and the bit-plane writeback (downstream, which consumes dout).
- Owns all clr/load/step timing, so the datapath stays purely a shift register.

Parameters:
- BWIN, 32, input data bit depth of the controlled quantser.
- BWMSBIDX, $clog2(BWIN), width of the MSB index.
- BWPREC, $clog2(BWIN)+1, width of the output precision field (legal range 0..BWIN).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; accepted when start && start_ready.
- start_ready  output  1  high only in IDLE.
- msbidx_in  input  BWMSBIDX  MSB position for this conversion; sampled on accept.
- prec_in  input  BWPREC  number of output bits; sampled on accept.
- q_clr  output  1  quantser clear.
- q_load  output  1  quantser load.
- q_step  output  1  quantser step.
- q_msbidx  output  BWMSBIDX  latched MSB index, held stable for the whole conversion.
- bit_valid  output  1  quantser dout is a valid output bit.
- bit_ready  input  1  downstream accepts the bit.
- bit_idx  output  BWPREC  bit-plane index of the current bit, 0 = most significant.
- bit_last  output  1  current bit is the final one (bit_idx == prec-1).
- done  output  1  one-cycle pulse when the conversion completes.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- States: INIT, IDLE, LOAD, EMIT, DONE.
- Reset (async assert, any state, including mid-conversion):
  - state = INIT; counters and latches = 0.
  - q_load, q_step, bit_valid, bit_last, done, start_ready = 0.
  - q_msbidx = 0; bit_idx = 0.
  - q_clr = 1 while in reset.
- INIT: q_clr = 1 for exactly one cycle after rst_n deasserts, then go to IDLE. Guarantees a clean quantser after a mid-conversion reset.
- IDLE: start_ready = 1. On start:
  - Latch msbidx_in into q_msbidx and prec_in into prec.
  - If prec_in == 0: go to DONE; no load, no bits emitted.
  - Otherwise go to LOAD.
- LOAD: q_load = 1 for one cycle, then EMIT with count = 0.
  - Upstream must hold din valid from accept through the LOAD cycle.
- EMIT:
  - bit_valid = 1, bit_idx = count, bit_last = (count == prec-1).
  - q_step = bit_valid && bit_ready (combinational, never asserted outside EMIT).
  - On handshake with bit_last = 0: count++, remain in EMIT.
  - On handshake with bit_last = 1: go to DONE. The final step is still issued.
  - bit_ready low: everything holds, no step (stall of any length).
- DONE: done = 1 for one cycle, then IDLE. start is ignored in DONE.
- Timing:
  - Latency from accept to first bit_valid: 2 cycles.
  - Full-throughput conversion (prec = P, bit_ready tied high): accept-to-done = P+2 cycles. Next accept is possible the cycle after done.
- Precision boundaries:
  - prec > msbidx+1: bits below the LSB emit as 0 (shift-in zeros); the controller does not truncate.
  - prec > BWIN: clamp to BWIN on latch.
- Invariants:
  - q_load and q_step are never asserted in the same cycle.
  - q_clr is never asserted outside INIT.
  - q_msbidx changes only in IDLE on accept.

Decomposition:
- Shared package (quantser_pkg):
  - State encoding enum (INIT/IDLE/LOAD/EMIT/DONE).
  - Function clog2-based width constants BWMSBIDX/BWPREC derived from BWIN.
- No sub-module needed for the controller itself.
- Optional wrapper quantser_unit instantiates quantser + quantser_ctrl with q_* wired through, for bench convenience.

Test Plan:
- Basic: msbidx_in = 7, prec_in = 4, din = 0xB6, bit_ready = 1.
  - Expect q_load 1 cycle after accept.
  - Expect dout/bit_idx sequence 1/0, 0/1, 1/2, 1/3, bit_last on idx 3.
  - Expect done at accept+6.
- Backpressure: same stimulus, bit_ready low for 3 cycles at idx 1 → bit_valid and bit_idx = 1 held, no q_step, dout stable; sequence resumes unchanged, done at accept+9.
- Zero/overshoot precision:
  - prec_in = 0 → no q_load, done at accept+1.
  - msbidx_in = 2, prec_in = 5, din = 0x5 → bits 1,0,1,0,0.
- Clamp: BWIN = 32, prec_in = 33 → exactly 32 bits emitted, bit_last at idx 31.
- Reset mid-EMIT: assert rst_n low at idx 2.
  - All outputs 0 immediately (async), q_clr = 1.
  - After release: one q_clr cycle, start_ready = 1 the following cycle; quantser sr reads 0.
- Back-to-back: start held high → second accept the cycle after done; q_msbidx updates only at that accept.
